sp_minmax_reduce: RTL and testbench
===================================

SP_MINMAX_REDUCE -- requirements
Module: sp_minmax_reduce

Interface
REQ-001 SHALL have parameter IDX_W, default 16: element index / count width.
REQ-002 SHALL have parameter CANON_NAN, default 32'h7fc00000: result when every element is NaN.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1: in_data/in_last/func3 valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a beat; transfer when in_valid & in_ready.
REQ-007 SHALL have port in_data, input, 32: IEEE-754 single element.
REQ-008 SHALL have port in_last, input, 1: final element of the vector.
REQ-009 SHALL have port func3, input, 3: mode, sampled on the first beat only.
REQ-010 SHALL have port out_valid, output, 1: result/index/flag_invalid valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port result, output, 32: reduced value.
REQ-013 SHALL have port index, output, IDX_W: zero-based position of the selected element.
REQ-014 SHALL have port flag_invalid, output, 1: any sNaN seen in the vector.

Function
REQ-015 SHALL support modes: 000 MIN, 001 MAX, 010 ARGMIN, 011 ARGMAX, 100 MINMAG, 101 MAXMAG; MIN/ARGMIN share compare, MAX/ARGMAX share compare; *MAG compare |x| (sign ignored); 110/111 → result 0, index 0, flag_invalid still accumulated.
REQ-016 SHALL order values: -0 < +0; denormals compared exactly; -inf < finite < +inf.
REQ-017 SHALL ignore NaN elements for selection: a non-NaN always replaces a NaN accumulator; NaN never replaces a non-NaN accumulator.
REQ-018 SHALL return CANON_NAN with index 0 if all elements are NaN.
REQ-019 SHALL keep the earliest element on ties (equal values, incl. equal *MAG magnitudes with different sign).
REQ-020 SHALL set flag_invalid if any element is sNaN (exp all-ones, mant≠0, bit22=0); sticky for the vector.
REQ-021 SHALL implement FSM IDLE → ACC → OUT: IDLE: first beat loads accumulator, index 0, count 1, latches func3; in_last → OUT else → ACC. ACC: each beat compared with accumulator, one element per cycle, count++; in_last → OUT. OUT: out_valid=1; out_ready → IDLE.
REQ-022 SHALL drive in_ready=1 in IDLE/ACC, 0 in OUT and while rst is high.
REQ-023 SHALL assert out_valid the cycle after the in_last beat transfers; result/index/flag_invalid stable while out_valid & !out_ready.
REQ-024 SHALL accept a one-element vector (first beat with in_last) and return that element (or CANON_NAN if NaN).
REQ-025 SHALL wrap count modulo 2^IDX_W; vectors longer than 2^IDX_W report the wrapped index.
REQ-026 SHALL ignore func3 changes after the first beat of a vector.
REQ-027 SHALL allow in_valid gaps (bubbles) without state change.

Reset
REQ-028 SHALL on rst: state IDLE, out_valid 0, result 0, index 0, flag_invalid 0, count 0, latched mode 000.
REQ-029 SHALL discard a partially accumulated vector or pending result if rst asserts mid-operation; no out_valid follows.

Structure
REQ-030 SHALL place mode codes, CANON_NAN default, and FSM state encoding in shared package sp_fp_pkg.
REQ-031 SHALL use one combinational sub-module sp_fp_cmp (inputs a, b, mag_mode; outputs a_lt_b, a_eq_b, a_nan, b_nan, a_snan, b_snan).

Verification
REQ-032 MAX, 4 beats {3F800000, C0000000, 40400000, 40400000} → result 40400000, index 2, flag 0, out_valid one cycle after last.
REQ-033 MIN, {7FC00000, 80000000, 00000000} → result 80000000, index 1; all-NaN {7FC00000, 7F800001} → 7FC00000, index 0, flag 1.
REQ-034 MAXMAG, {C1200000, 41200000} → result C1200000, index 0 (tie keeps first).
REQ-035 Backpressure: out_ready low 5 cycles → outputs stable, in_ready 0; next vector accepted the cycle after out_ready handshake.
REQ-036 rst during ACC after 3 beats → out_valid never asserts; following single-beat vector 3F800000 → result 3F800000, index 0.

Source files
------------

// File: rtl/sp_fp_pkg.sv
// Shared definitions for the single-precision min/max reduction block:
// mode codes, canonical NaN default and FSM state encoding.
package sp_fp_pkg;

    localparam logic [2:0] MODE_MIN    = 3'b000;
    localparam logic [2:0] MODE_MAX    = 3'b001;
    localparam logic [2:0] MODE_ARGMIN = 3'b010;
    localparam logic [2:0] MODE_ARGMAX = 3'b011;
    localparam logic [2:0] MODE_MINMAG = 3'b100;
    localparam logic [2:0] MODE_MAXMAG = 3'b101;

    localparam logic [31:0] CANON_NAN_DEFAULT = 32'h7fc00000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Codes 110/111 select no element and report a zero result.
    function automatic logic mode_is_null(input logic [2:0] mode);
        return mode[2] & mode[1];
    endfunction

endpackage

// File: rtl/sp_fp_cmp.sv
// Combinational IEEE-754 single compare with optional magnitude mode and
// NaN / signalling-NaN classification of both operands.
module sp_fp_cmp (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mag_mode,
    output logic        a_lt_b,
    output logic        a_eq_b,
    output logic        a_nan,
    output logic        b_nan,
    output logic        a_snan,
    output logic        b_snan
);

    logic [31:0] a_m;
    logic [31:0] b_m;
    logic [31:0] a_key;
    logic [31:0] b_key;

    // Map sign-magnitude onto an unsigned key so that -0 < +0 and
    // denormals/infinities order exactly with a plain integer compare.
    always_comb begin
        a_m    = {a[31] & ~mag_mode, a[30:0]};
        b_m    = {b[31] & ~mag_mode, b[30:0]};
        a_key  = a_m[31] ? ~a_m : {1'b1, a_m[30:0]};
        b_key  = b_m[31] ? ~b_m : {1'b1, b_m[30:0]};
        a_lt_b = a_key < b_key;
        a_eq_b = a_key == b_key;
        a_nan  = (&a[30:23]) & (|a[22:0]);
        b_nan  = (&b[30:23]) & (|b[22:0]);
        a_snan = a_nan & ~a[22];
        b_snan = b_nan & ~b[22];
    end

endmodule

// File: rtl/sp_minmax_reduce.sv
// Streaming min/max/argmin/argmax/magnitude reduction over a vector of
// single-precision elements, one element per cycle, with valid/ready I/O.
module sp_minmax_reduce
    import sp_fp_pkg::*;
#(
    parameter int          IDX_W     = 16,
    parameter logic [31:0] CANON_NAN = CANON_NAN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic [2:0]       func3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [IDX_W-1:0] index,
    output logic             flag_invalid
);

    state_t            state_reg, state_next;
    logic [2:0]        mode_reg;
    logic [31:0]       acc_reg;
    logic [IDX_W-1:0]  acc_idx_reg;
    logic [IDX_W-1:0]  count_reg;
    logic              flag_acc_reg;
    logic [31:0]       result_reg;
    logic [IDX_W-1:0]  index_reg;
    logic              flag_reg;

    logic              take;
    logic              first;
    logic [2:0]        sel_mode;
    logic              mag_mode;
    logic              want_min;
    logic              a_lt_b, a_eq_b, in_nan, acc_nan, in_snan, acc_snan;
    logic              better;
    logic              replace;
    logic [31:0]       acc_next;
    logic [IDX_W-1:0]  acc_idx_next;
    logic              acc_nan_next;
    logic              flag_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_ACC: if (take) state_next = in_last ? ST_OUT : ST_ACC;
            ST_OUT:          if (out_ready) state_next = ST_IDLE;
            default:         state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !rst && (state_reg != ST_OUT);
        out_valid = (state_reg == ST_OUT);
    end

    sp_fp_cmp u_cmp (
        .a        (in_data),
        .b        (acc_reg),
        .mag_mode (mag_mode),
        .a_lt_b   (a_lt_b),
        .a_eq_b   (a_eq_b),
        .a_nan    (in_nan),
        .b_nan    (acc_nan),
        .a_snan   (in_snan),
        .b_snan   (acc_snan)
    );

    // The first beat takes func3 live; later beats use the latched mode.
    always_comb begin
        take     = in_valid & in_ready;
        first    = (state_reg == ST_IDLE);
        sel_mode = first ? func3 : mode_reg;
        mag_mode = (sel_mode == MODE_MINMAG) || (sel_mode == MODE_MAXMAG);
        want_min = (sel_mode == MODE_MIN) || (sel_mode == MODE_ARGMIN) ||
                   (sel_mode == MODE_MINMAG);
        better   = want_min ? a_lt_b : !(a_lt_b || a_eq_b);
        replace  = !in_nan && (acc_nan || better);

        acc_next     = (first || replace) ? in_data : acc_reg;
        acc_idx_next = first ? '0 : (replace ? count_reg : acc_idx_reg);
        acc_nan_next = (first || replace) ? in_nan : acc_nan;
        flag_next    = first ? in_snan : (flag_acc_reg | in_snan | acc_snan);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg     <= MODE_MIN;
            acc_reg      <= '0;
            acc_idx_reg  <= '0;
            count_reg    <= '0;
            flag_acc_reg <= 1'b0;
            result_reg   <= '0;
            index_reg    <= '0;
            flag_reg     <= 1'b0;
        end else if (take) begin
            if (first) mode_reg <= func3;
            acc_reg      <= acc_next;
            acc_idx_reg  <= acc_idx_next;
            count_reg    <= first ? IDX_W'(1) : count_reg + 1'b1;
            flag_acc_reg <= flag_next;
            if (in_last) begin
                flag_reg <= flag_next;
                if (mode_is_null(sel_mode) || acc_nan_next) begin
                    result_reg <= mode_is_null(sel_mode) ? 32'h0 : CANON_NAN;
                    index_reg  <= '0;
                end else begin
                    result_reg <= acc_next;
                    index_reg  <= acc_idx_next;
                end
            end
        end
    end

    assign result       = result_reg;
    assign index        = index_reg;
    assign flag_invalid = flag_reg;

endmodule

// File: tb/tb_sp_minmax_reduce.sv
// Scoreboard bench for sp_minmax_reduce: directed vectors plus a randomised
// sweep checked against an independent sign-magnitude reference model.
module tb_sp_minmax_reduce;

    localparam int IDX_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic [2:0]       func3;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;
    logic [IDX_W-1:0] index;
    logic             flag_invalid;

    sp_minmax_reduce #(.IDX_W(IDX_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .func3        (func3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .index        (index),
        .flag_invalid (flag_invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      res;
        logic [IDX_W-1:0] idx;
        logic             flg;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] vec [0:15];
    logic [31:0] pool [0:11];
    int          checks = 0;
    int          failures = 0;

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] != 23'h0);
    endfunction

    function automatic bit ref_less(input logic [31:0] a, input logic [31:0] b, input bit mag);
        logic sa, sb_;
        sa  = mag ? 1'b0 : a[31];
        sb_ = mag ? 1'b0 : b[31];
        if (sa != sb_) return sa;
        if (!sa) return a[30:0] < b[30:0];
        return a[30:0] > b[30:0];
    endfunction

    function automatic exp_t ref_model(input int n, input logic [2:0] mode);
        exp_t e;
        int   best = -1;
        bit   mag = (mode == 3'b100) || (mode == 3'b101);
        bit   mn  = (mode == 3'b000) || (mode == 3'b010) || (mode == 3'b100);
        e.flg = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (is_nan(vec[i]) && !vec[i][22]) e.flg = 1'b1;
            if (!is_nan(vec[i])) begin
                if (best < 0) best = i;
                else if (mn && ref_less(vec[i], vec[best], mag)) best = i;
                else if (!mn && ref_less(vec[best], vec[i], mag)) best = i;
            end
        end
        if (mode[2:1] == 2'b11) begin
            e.res = 32'h0;
            e.idx = '0;
        end else if (best < 0) begin
            e.res = 32'h7fc00000;
            e.idx = '0;
        end else begin
            e.res = vec[best];
            e.idx = IDX_W'(best);
        end
        return e;
    endfunction

    // Drives vec[0..n-1]; func3 is scrambled after the first beat.
    task automatic send_vec(input int n, input logic [2:0] mode, input bit bubbles);
        for (int i = 0; i < n; i++) begin
            if (bubbles && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                in_data  = 32'hdeadbeef;
                func3    = 3'($urandom);
                @(posedge clk); #1;
            end
            for (int w = 0; w < 50 && !in_ready; w++) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = vec[i];
            in_last  = (i == n - 1);
            func3    = (i == 0) ? mode : 3'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency: out_valid=%b required 1 one cycle after last beat", out_valid);
        end
    endtask

    task automatic check_result(input string name);
        exp_t e;
        int   w = 0;
        while (!out_valid && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        checks++;
        if (!out_valid || sb.size() == 0) begin
            failures++;
            $display("FAIL %s: out_valid=%b queue=%0d, no result to compare", name, out_valid, sb.size());
            return;
        end
        e = sb.pop_front();
        if (result !== e.res || index !== e.idx || flag_invalid !== e.flg) begin
            failures++;
            $display("FAIL %s: got result=%h index=%0d flag=%b required result=%h index=%0d flag=%b",
                     name, result, index, flag_invalid, e.res, e.idx, e.flg);
        end else begin
            $display("txn %s: result=%h index=%0d flag=%b", name, result, index, flag_invalid);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic push(input logic [31:0] r, input int i, input logic f);
        exp_t e;
        e.res = r;
        e.idx = IDX_W'(i);
        e.flg = f;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0 ||
            index !== '0 || flag_invalid !== 1'b0) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b result=%h index=%0d flag=%b required 0/0/0/0/0",
                     in_ready, out_valid, result, index, flag_invalid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        vec[0] = 32'h3f800000; vec[1] = 32'hc0000000; vec[2] = 32'h40400000; vec[3] = 32'h40400000;
        push(32'h40400000, 2, 1'b0); send_vec(4, 3'b001, 1'b0); check_result("max");
        vec[0] = 32'h7fc00000; vec[1] = 32'h80000000; vec[2] = 32'h00000000;
        push(32'h80000000, 1, 1'b0); send_vec(3, 3'b000, 1'b0); check_result("min_zero");
        vec[0] = 32'h7fc00000; vec[1] = 32'h7f800001;
        push(32'h7fc00000, 0, 1'b1); send_vec(2, 3'b000, 1'b0); check_result("all_nan");
        vec[0] = 32'hc1200000; vec[1] = 32'h41200000;
        push(32'hc1200000, 0, 1'b0); send_vec(2, 3'b101, 1'b0); check_result("maxmag_tie");
        vec[0] = 32'hc0000000; vec[1] = 32'h3f800000; vec[2] = 32'hbf800000;
        push(32'h3f800000, 1, 1'b0); send_vec(3, 3'b100, 1'b0); check_result("minmag_tie");
        vec[0] = 32'h00000002; vec[1] = 32'h00000001; vec[2] = 32'h80000001;
        push(32'h80000001, 2, 1'b0); send_vec(3, 3'b010, 1'b0); check_result("argmin_denorm");
        vec[0] = 32'h00000001; vec[1] = 32'h00000002; vec[2] = 32'h7f800000; vec[3] = 32'hff800000;
        push(32'h7f800000, 2, 1'b0); send_vec(4, 3'b011, 1'b0); check_result("argmax_inf");
        vec[0] = 32'h3f800000; vec[1] = 32'h7f800001;
        push(32'h0, 0, 1'b1); send_vec(2, 3'b110, 1'b0); check_result("null_mode");
        vec[0] = 32'h7fa00000;
        push(32'h7fc00000, 0, 1'b1); send_vec(1, 3'b001, 1'b0); check_result("single_snan");
        vec[0] = 32'hbf800000;
        push(32'hbf800000, 0, 1'b0); send_vec(1, 3'b000, 1'b0); check_result("single");
        vec[0] = 32'h3f800000; vec[1] = 32'hc0000000; vec[2] = 32'h40400000; vec[3] = 32'h40400000;
        push(32'h40400000, 2, 1'b0); send_vec(4, 3'b001, 1'b1); check_result("max_bubbles");
    endtask

    task automatic test_backpressure();
        vec[0] = 32'h40a00000; vec[1] = 32'h3f800000;
        push(32'h3f800000, 1, 1'b0);
        send_vec(2, 3'b000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h3f800000 ||
                index !== IDX_W'(1) || flag_invalid !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold: out_valid=%b in_ready=%b result=%h index=%0d required 1/0/3f800000/1",
                         out_valid, in_ready, result, index);
            end
            @(posedge clk); #1;
        end
        check_result("backpressure");
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_handshake: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        vec[0] = 32'h40000000;
        push(32'h40000000, 0, 1'b0); send_vec(1, 3'b001, 1'b0); check_result("after_bp");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h41000000 + 32'(i);
            in_last  = 1'b0;
            func3    = 3'b001;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_ready: in_ready=%b required 0", in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_discard: out_valid=%b required 0", out_valid);
            end
            @(posedge clk); #1;
        end
        vec[0] = 32'h3f800000;
        push(32'h3f800000, 0, 1'b0); send_vec(1, 3'b001, 1'b0); check_result("after_rst");
    endtask

    task automatic test_random();
        exp_t        e;
        int          n;
        logic [2:0]  mode;
        for (int t = 0; t < 40; t++) begin
            n    = $urandom_range(1, 12);
            mode = 3'($urandom_range(0, 7));
            for (int i = 0; i < n; i++) vec[i] = pool[$urandom_range(0, 11)];
            e = ref_model(n, mode);
            sb.push_back(e);
            send_vec(n, mode, 1'b1);
            check_result("random");
        end
    endtask

    initial begin
        pool[0]  = 32'h00000000; pool[1]  = 32'h80000000; pool[2]  = 32'h3f800000;
        pool[3]  = 32'hbf800000; pool[4]  = 32'h00000001; pool[5]  = 32'h80000001;
        pool[6]  = 32'h7f800000; pool[7]  = 32'hff800000; pool[8]  = 32'h7fc00000;
        pool[9]  = 32'hff800123; pool[10] = 32'h40400000; pool[11] = 32'hc0400000;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        func3     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
